// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator; every output is registered from the next-state counts.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_count output.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_count
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEGIN = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        blank_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        frame_start_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        h_next           = hcount + 11'd1;
        v_next           = vcount;
        frame_start_next = 1'b0;
        if (hcount >= H_LAST) begin
            h_next = '0;
            if (vcount >= V_LAST) begin
                v_next           = '0;
                frame_start_next = 1'b1;
            end else begin
                v_next = vcount + 11'd1;
            end
        end

        // Decode the position the counters are about to hold, so the flops stay aligned.
        blank_next = (h_next >= H_VIS) || (v_next >= V_VIS);
        hsync_next = ((h_next >= HS_BEGIN) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_next = ((v_next >= VS_BEGIN) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            blank       <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            blank       <= blank_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            frame_start <= frame_start_next;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Counts completed frames; steps on the same edge that raises frame_start.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (frame_start_next) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-timing DUT checked against a table of line positions; two reduced-timing DUTs
// (both sync polarities) checked every cycle against an arithmetic raster model with random resets.
module tb_vga_timing_gen;

    // Reduced timing so whole frames (and 256+ of them) fit a short run.
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 5, S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    typedef struct {
        int n;
        int hc;
        int vc;
        bit blank;
        bit hsync;
        bit vsync;
    } vec_t;

    typedef struct {
        int hc;
        int vc;
        bit blank;
        bit hsync;
        bit vsync;
        bit fs;
        int fcnt;
    } exp_t;

    logic clk;
    logic rst_d, rst_s;

    logic [10:0] hc_d, vc_d, hc_s, vc_s, hc_p, vc_p;
    logic        bl_d, hs_d, vs_d, fs_d;
    logic        bl_s, hs_s, vs_s, fs_s;
    logic        bl_p, hs_p, vs_p, fs_p;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]  fc_d, fc_s, fc_p;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int sn    = 0;
    int vs_act_cnt, fs_cnt;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    vga_timing_gen u_def (
        .clk_25MHz  (clk),
        .reset      (rst_d),
        .hcount     (hc_d),
        .vcount     (vc_d),
        .blank      (bl_d),
        .hsync      (hs_d),
        .vsync      (vs_d),
        .frame_start(fs_d)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_d)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk_25MHz  (clk),
        .reset      (rst_s),
        .hcount     (hc_s),
        .vcount     (vc_s),
        .blank      (bl_s),
        .hsync      (hs_s),
        .vsync      (vs_s),
        .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_s)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b1)
    ) u_pol (
        .clk_25MHz  (clk),
        .reset      (rst_s),
        .hcount     (hc_p),
        .vcount     (vc_p),
        .blank      (bl_p),
        .hsync      (hs_p),
        .vsync      (vs_p),
        .frame_start(fs_p)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc_p)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Raster position n cycles after reset release, from plain division/modulo.
    function automatic exp_t model(input int n, input bit pol, input bit in_rst);
        exp_t e;
        if (in_rst) begin
            e.hc = 0; e.vc = 0; e.blank = 1'b0; e.hsync = ~pol; e.vsync = ~pol;
            e.fs = 1'b0; e.fcnt = 0;
            return e;
        end
        e.hc    = n % S_HT;
        e.vc    = (n / S_HT) % S_VT;
        e.blank = (e.hc >= S_HV) || (e.vc >= S_VV);
        e.hsync = (e.hc >= S_HV + S_HF && e.hc < S_HV + S_HF + S_HS) ? pol : ~pol;
        e.vsync = (e.vc >= S_VV + S_VF && e.vc < S_VV + S_VF + S_VS) ? pol : ~pol;
        e.fs    = (n > 0) && (n % S_FRAME == 0);
        e.fcnt  = (n / S_FRAME) % 256;
        return e;
    endfunction

    task automatic cmp_small();
        exp_t es, ep;
        es = model(sn, 1'b0, rst_s);
        ep = model(sn, 1'b1, rst_s);
        check("small.hcount", 32'(hc_s), 32'(es.hc));
        check("small.vcount", 32'(vc_s), 32'(es.vc));
        check("small.blank",  32'(bl_s), 32'(es.blank));
        check("small.hsync",  32'(hs_s), 32'(es.hsync));
        check("small.vsync",  32'(vs_s), 32'(es.vsync));
        check("small.frame_start", 32'(fs_s), 32'(es.fs));
        check("pol.hcount",   32'(hc_p), 32'(ep.hc));
        check("pol.vcount",   32'(vc_p), 32'(ep.vc));
        check("pol.blank",    32'(bl_p), 32'(ep.blank));
        check("pol.hsync",    32'(hs_p), 32'(ep.hsync));
        check("pol.vsync",    32'(vs_p), 32'(ep.vsync));
        check("pol.frame_start", 32'(fs_p), 32'(ep.fs));
`ifdef VGA_FRAME_CNT_EN
        check("small.frame_count", 32'(fc_s), 32'(es.fcnt));
        check("pol.frame_count",   32'(fc_p), 32'(ep.fcnt));
`endif
        if (vs_s == 1'b0) vs_act_cnt++;
        if (fs_s) fs_cnt++;
    endtask

    task automatic run_small(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            sn++;
            cmp_small();
        end
    endtask

    initial begin
        vec_t tbl[12];
        int   idx, hs_low, blank_hi, fs_def;
        int   hold;

        //           n     hc   vc  blank hsync vsync
        tbl[0]  = '{0,    0,   0,  1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1,    1,   0,  1'b0, 1'b1, 1'b1};
        tbl[2]  = '{639,  639, 0,  1'b0, 1'b1, 1'b1};
        tbl[3]  = '{640,  640, 0,  1'b1, 1'b1, 1'b1};
        tbl[4]  = '{655,  655, 0,  1'b1, 1'b1, 1'b1};
        tbl[5]  = '{656,  656, 0,  1'b1, 1'b0, 1'b1};
        tbl[6]  = '{751,  751, 0,  1'b1, 1'b0, 1'b1};
        tbl[7]  = '{752,  752, 0,  1'b1, 1'b1, 1'b1};
        tbl[8]  = '{799,  799, 0,  1'b1, 1'b1, 1'b1};
        tbl[9]  = '{800,  0,   1,  1'b0, 1'b1, 1'b1};
        tbl[10] = '{1456, 656, 1,  1'b1, 1'b0, 1'b1};
        tbl[11] = '{1600, 0,   2,  1'b0, 1'b1, 1'b1};

        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("def.reset.hcount", 32'(hc_d), 32'd0);
        check("def.reset.vcount", 32'(vc_d), 32'd0);
        check("def.reset.blank",  32'(bl_d), 32'd0);
        check("def.reset.hsync",  32'(hs_d), 32'd1);
        check("def.reset.vsync",  32'(vs_d), 32'd1);
        check("def.reset.frame_start", 32'(fs_d), 32'd0);

        // Default timing: first two lines of the frame, table entries at the boundaries.
        rst_d = 1'b0;
        #1;
        idx = 0; hs_low = 0; blank_hi = 0; fs_def = 0;
        for (int n = 0; n <= 1600; n++) begin
            if (n > 0) @(negedge clk);
            if (idx < 12 && tbl[idx].n == n) begin
                check("def.hcount", 32'(hc_d), 32'(tbl[idx].hc));
                check("def.vcount", 32'(vc_d), 32'(tbl[idx].vc));
                check("def.blank",  32'(bl_d), 32'(tbl[idx].blank));
                check("def.hsync",  32'(hs_d), 32'(tbl[idx].hsync));
                check("def.vsync",  32'(vs_d), 32'(tbl[idx].vsync));
                idx++;
            end
            if (n < 800) begin
                if (hs_d == 1'b0) hs_low++;
                if (bl_d == 1'b1) blank_hi++;
            end
            if (fs_d) fs_def++;
        end
        check("def.hsync_low_cycles", 32'(hs_low), 32'd96);
        check("def.blank_cycles_line0", 32'(blank_hi), 32'd160);
        check("def.no_frame_start", 32'(fs_def), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        check("def.frame_count", 32'(fc_d), 32'd0);
`endif

        // Reduced timing: reset values, then one frame with window statistics.
        cmp_small();
        rst_s = 1'b0;
        sn = 0;
        #1;
        cmp_small();
        vs_act_cnt = 0;
        fs_cnt = 0;
        run_small(S_FRAME);
        check("small.vsync_cycles_frame", 32'(vs_act_cnt), 32'(S_VS * S_HT));
        check("small.frame_start_pulses", 32'(fs_cnt), 32'd1);

        // Enough further frames to carry frame_count through its 255 -> 0 wrap.
        run_small(257 * S_FRAME);

        // Random mid-frame async resets, each followed by a random run (some past a full frame).
        for (int ep = 0; ep < 8; ep++) begin
            run_small(int'($urandom_range(2 * S_FRAME, 1)));
            #5 rst_s = 1'b1;
            #1 cmp_small();
            hold = int'($urandom_range(4, 1));
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                cmp_small();
            end
            rst_s = 1'b0;
            sn = 0;
            #1 cmp_small();
        end
        fs_cnt = 0;
        run_small(S_FRAME + 3);
        check("small.frame_start_after_reset", 32'(fs_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
